// File: rtl/can_tx_serializer_pkg.sv
// Shared CAN transmit definitions: field widths, bus levels, stuffing limit
// and the serializer state encoding.
package can_tx_serializer_pkg;

  localparam int FRAME_W     = 83;
  localparam int CRC_W       = 15;
  localparam int STUFF_LIMIT = 5;
  localparam int RUN_W       = 3;
  localparam int CNT_W       = 7;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FRAME    = 3'd1,
    ST_CRC      = 3'd2,
    ST_CRC_DEL  = 3'd3,
    ST_ACK_SLOT = 3'd4,
    ST_ACK_DEL  = 3'd5,
    ST_EOF      = 3'd6,
    ST_IFS      = 3'd7
  } state_e;

endpackage

// File: rtl/can_bit_stuffer.sv
// Tracks the run length of identical transmitted bits and requests a
// complement stuff bit once the run reaches the stuffing limit.
module can_bit_stuffer
  import can_tx_serializer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic push_i,
  input  logic bit_i,
  output logic stuff_req_o,
  output logic stuff_bit_o
);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clear_i) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (push_i) begin
      last_d = bit_i;
      // a zero run means no bit sent yet, so the first bit always starts a run
      if ((run_q != '0) && (bit_i == last_q)) run_d = run_q + 1'b1;
      else                                    run_d = RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign stuff_req_o = (run_q == RUN_W'(STUFF_LIMIT));
  assign stuff_bit_o = ~last_q;

endmodule

// File: rtl/can_tx_serializer.sv
// CAN frame serializer: shifts out frame and CRC with bit stuffing, then the
// fixed recessive trailer, one bus bit per i_bit_tick.
module can_tx_serializer
  import can_tx_serializer_pkg::*;
#(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_bit_tick,
  input  logic                i_start,
  input  logic [FRAME_W-1:0]  i_frame,
  input  logic [CRC_W-1:0]    i_crc,
  input  logic                i_rx,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_ack_err
);

  // state       | meaning (state names the next bit a tick will drive)
  // ST_IDLE     | bus recessive, waiting for i_start
  // ST_FRAME    | sending frame bits (plus stuff bits)
  // ST_CRC      | sending CRC bits (plus stuff bits)
  // ST_CRC_DEL  | trailing stuff bit if pending, else CRC delimiter
  // ST_ACK_SLOT | drive recessive ACK slot
  // ST_ACK_DEL  | sample i_rx (slot ends), drive ACK delimiter
  // ST_EOF      | EOF_BITS recessive bits
  // ST_IFS      | IFS_BITS recessive bits, last one completes the frame

  state_e             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CRC_W-1:0]   crc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tx_q, busy_q, done_q, ack_err_q;

  logic stuff_req, stuff_bit, push, clear, tx_bit;

  always_comb begin
    tx_bit = stuff_req ? stuff_bit :
             ((state_q == ST_FRAME) ? frame_q[FRAME_W-1] : crc_q[CRC_W-1]);
    push   = i_bit_tick && ((state_q == ST_FRAME) || (state_q == ST_CRC) ||
                            ((state_q == ST_CRC_DEL) && stuff_req));
    clear  = (state_q == ST_IDLE) && i_start;
  end

  can_bit_stuffer u_stuffer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .push_i      (push),
    .bit_i       (tx_bit),
    .stuff_req_o (stuff_req),
    .stuff_bit_o (stuff_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= RECESSIVE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= RECESSIVE;
          if (i_start) begin
            frame_q   <= i_frame;
            crc_q     <= i_crc;
            cnt_q     <= CNT_W'(FRAME_W - 1);
            busy_q    <= 1'b1;
            ack_err_q <= 1'b0;
            state_q   <= ST_FRAME;
          end
        end
        ST_FRAME: if (i_bit_tick) begin
          tx_q <= tx_bit;
          if (!stuff_req) begin
            frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == '0) begin
              cnt_q   <= CNT_W'(CRC_W - 1);
              state_q <= ST_CRC;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        ST_CRC: if (i_bit_tick) begin
          tx_q <= tx_bit;
          if (!stuff_req) begin
            crc_q <= {crc_q[CRC_W-2:0], 1'b0};
            if (cnt_q == '0) state_q <= ST_CRC_DEL;
            else             cnt_q   <= cnt_q - 1'b1;
          end
        end
        ST_CRC_DEL: if (i_bit_tick) begin
          if (stuff_req) begin
            tx_q <= stuff_bit;
          end else begin
            tx_q    <= RECESSIVE;
            state_q <= ST_ACK_SLOT;
          end
        end
        ST_ACK_SLOT: if (i_bit_tick) begin
          tx_q    <= RECESSIVE;
          state_q <= ST_ACK_DEL;
        end
        ST_ACK_DEL: if (i_bit_tick) begin
          ack_err_q <= (i_rx == RECESSIVE);
          tx_q      <= RECESSIVE;
          cnt_q     <= CNT_W'(EOF_BITS - 1);
          state_q   <= ST_EOF;
        end
        ST_EOF: if (i_bit_tick) begin
          tx_q <= RECESSIVE;
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(IFS_BITS - 1);
            state_q <= ST_IFS;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_IFS: if (i_bit_tick) begin
          tx_q <= RECESSIVE;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_ack_err = ack_err_q;

endmodule

// File: tb/tb_can_tx_serializer.sv
// Directed bench for can_tx_serializer: vector table of whole frames plus
// hand sequences for ignored restarts, mid-frame reset and missing ticks.
module tb_can_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_bit_tick;
  logic        i_start;
  logic [82:0] i_frame;
  logic [14:0] i_crc;
  logic        i_rx;
  logic        o_tx, o_busy, o_done, o_ack_err;

  can_tx_serializer #(.EOF_BITS(7), .IFS_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_bit_tick(i_bit_tick),
    .i_start   (i_start),
    .i_frame   (i_frame),
    .i_crc     (i_crc),
    .i_rx      (i_rx),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_ack_err (o_ack_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit   tick_en = 1'b1;
  int   cyc = 0;
  logic obs_bits[256];
  int   obs_n = 0;
  int   done_cnt = 0;
  logic ack_at_done = 1'b0;
  logic exp_bits[256];
  int   exp_n = 0;

  typedef struct {
    logic [82:0] frame;
    logic [14:0] crc;
    logic        rx;
    logic        on_tick;
    int          ticks;
    logic        ack;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected bus stream: data bits with stuffing, then 13 recessive trailer bits.
  function automatic void build_model(input logic [82:0] f, input logic [14:0] c);
    logic [97:0] d;
    logic        last;
    int          run;
    d = {f, c};
    exp_n = 0;
    last = 1'b0;
    run = 0;
    for (int i = 97; i >= 0; i--) begin
      exp_bits[exp_n] = d[i];
      exp_n++;
      run = (run > 0 && d[i] == last) ? run + 1 : 1;
      last = d[i];
      if (run == 5) begin
        exp_bits[exp_n] = ~d[i];
        exp_n++;
        last = ~d[i];
        run = 1;
      end
    end
    for (int i = 0; i < 13; i++) begin
      exp_bits[exp_n] = 1'b1;
      exp_n++;
    end
  endfunction

  initial begin
    i_bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      i_bit_tick = tick_en && (cyc % 4 == 0);
    end
  end

  // Records o_tx after every tick edge that the DUT saw while busy.
  initial begin
    logic busy_n;
    forever begin
      @(negedge clk);
      busy_n = o_busy;
      @(posedge clk);
      #1;
      if (i_bit_tick && busy_n && obs_n < 256) begin
        obs_bits[obs_n] = o_tx;
        obs_n++;
      end
      if (o_done) begin
        done_cnt++;
        ack_at_done = o_ack_err;
      end
    end
  end

  // mode: 0 normal, 1 i_start pulses at ticks 10/60, 2 reset at tick 40, 3 tick pause at tick 30
  task automatic run_frame(input string name, input logic [82:0] f, input logic [14:0] c,
                           input logic rx, input logic on_tick, input int mode,
                           input int exp_ticks, input logic exp_ack);
    int   guard, mism, nbefore, bad;
    bit   p10, p60, paused;
    logic held;
    p10 = 0; p60 = 0; paused = 0;
    build_model(f, c);
    i_rx = rx;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (i_bit_tick !== on_tick && guard < 10);
    i_start = 1'b1;
    i_frame = f;
    i_crc = c;
    obs_n = 0;
    done_cnt = 0;
    @(negedge clk); #1;
    i_start = 1'b0;
    i_frame = ~f;
    i_crc = ~c;
    check({name, " busy_after_accept"}, o_busy, 1);
    check({name, " ack_err_cleared"}, o_ack_err, 0);
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
      i_start = 1'b0;
      if (mode == 1 && obs_n == 10 && !p10) begin
        p10 = 1; i_start = 1'b1; i_frame = 83'h0; i_crc = 15'h0;
      end
      if (mode == 1 && obs_n == 60 && !p60) begin
        p60 = 1; i_start = 1'b1; i_frame = 83'h0; i_crc = 15'h0;
      end
      if (mode == 2 && obs_n == 40) begin
        rst = 1'b1;
        #1;
        check({name, " rst_tx"}, o_tx, 1);
        check({name, " rst_busy"}, o_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        check({name, " rst_no_done"}, done_cnt, 0);
        check({name, " rst_idle_tx"}, o_tx, 1);
        return;
      end
      if (mode == 3 && obs_n == 30 && !paused) begin
        paused = 1;
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        held = o_tx;
        nbefore = obs_n;
        bad = 0;
        repeat (60) begin
          @(negedge clk); #1;
          if (o_tx !== held) bad++;
        end
        check({name, " pause_tx_hold"}, bad, 0);
        check({name, " pause_no_ticks"}, obs_n, nbefore);
        check({name, " pause_busy"}, o_busy, 1);
        tick_en = 1'b1;
      end
    end
    check({name, " done_seen"}, (done_cnt > 0), 1);
    if (exp_ticks > 0) check({name, " ticks"}, obs_n, exp_ticks);
    check({name, " ticks_model"}, obs_n, exp_n);
    mism = 0;
    for (int i = 0; i < exp_n; i++)
      if (i >= obs_n || obs_bits[i] !== exp_bits[i]) mism++;
    check({name, " stream_mismatches"}, mism, 0);
    check({name, " ack_err_at_done"}, ack_at_done, exp_ack);
    @(negedge clk); #1;
    check({name, " done_single_pulse"}, done_cnt, 1);
    check({name, " busy_low_after"}, o_busy, 0);
    repeat (5) @(negedge clk);
    #1;
    check({name, " ack_err_hold"}, o_ack_err, exp_ack);
  endtask

  initial begin
    logic [82:0] alt;
    for (int i = 0; i < 83; i++) alt[i] = (i % 2 == 1);

    vecs[0] = '{frame: 83'h0, crc: 15'h0,    rx: 1'b0, on_tick: 1'b0, ticks: 130, ack: 1'b0};
    vecs[1] = '{frame: alt,   crc: 15'h5555, rx: 1'b1, on_tick: 1'b1, ticks: 111, ack: 1'b1};
    vecs[2] = '{frame: alt,   crc: 15'h2A9F, rx: 1'b0, on_tick: 1'b0, ticks: 112, ack: 1'b0};
    vecs[3] = '{frame: ~83'h0, crc: 15'h7FFF, rx: 1'b1, on_tick: 1'b1, ticks: 130, ack: 1'b1};
    vecs[4] = '{frame: 83'h0, crc: 15'h7FFF, rx: 1'b0, on_tick: 1'b0, ticks: 130, ack: 1'b0};

    rst = 1'b1;
    i_start = 1'b0;
    i_frame = '0;
    i_crc = '0;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_tx", o_tx, 1);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_ack_err", o_ack_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("idle_tx", o_tx, 1);

    for (int v = 0; v < 5; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].crc, vecs[v].rx,
                vecs[v].on_tick, 0, vecs[v].ticks, vecs[v].ack);
      if (v == 2) begin
        check("crc_end_last_bit", obs_bits[97], 1);
        check("crc_end_stuff", obs_bits[98], 0);
        check("crc_end_delim", obs_bits[99], 1);
      end
    end

    run_frame("restart_ignored", alt, 15'h5555, 1'b0, 1'b0, 1, 111, 1'b0);
    run_frame("midframe_reset", 83'h0, 15'h0, 1'b0, 1'b0, 2, 0, 1'b0);
    run_frame("after_reset", alt, 15'h2A9F, 1'b1, 1'b0, 0, 112, 1'b1);
    run_frame("tick_pause", 83'h0, 15'h0, 1'b1, 1'b0, 3, 130, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/can_tx_serializer.md
CAN_TX_SERIALIZER -- requirements
Module: can_tx_serializer

Interface
REQ-001 Parameter EOF_BITS, default 7: recessive end-of-frame bits sent after ACK delimiter.
REQ-002 Parameter IFS_BITS, default 3: recessive intermission bits before returning idle.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 i_bit_tick  in  1  one-cycle strobe per CAN bit time; o_tx advances only on ticks.
REQ-006 i_start  in  1  request to transmit; accepted only in IDLE.
REQ-007 i_frame  in  83  SOF..data field, MSB (bit 82) sent first; same vector fed to the CRC15 block.
REQ-008 i_crc  in  15  CRC15 of i_frame, MSB (bit 14) sent first; valid together with i_start.
REQ-009 i_rx  in  1  bus receive level, sampled in ACK slot.
REQ-010 o_tx  out  1  serial bus bit; 1 = recessive.
REQ-011 o_busy  out  1  high from cycle after acceptance until IFS complete.
REQ-012 o_done  out  1  one-cycle pulse on frame completion.
REQ-013 o_ack_err  out  1  valid with o_done; 1 = no dominant ACK seen.

Function
REQ-014 States: IDLE, FRAME, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS.
REQ-015 IDLE: o_tx=1; i_start=1 captures i_frame and i_crc into shift registers, sets o_busy next cycle, enters FRAME.
REQ-016 i_start while o_busy=1 is ignored; captured data does not change mid-frame.
REQ-017 On each i_bit_tick in FRAME/CRC, o_tx updates in that cycle's registered output: next data bit or stuff bit.
REQ-018 First bit on bus (SOF = i_frame[82]) appears on the first i_bit_tick after acceptance; acceptance and tick in the same cycle -> SOF on the next tick.
REQ-019 Stuffing: after 5 consecutive identical transmitted bits (stuff bits counted), insert one complement bit; the run restarts at the stuff bit.
REQ-020 Stuffing is continuous across the FRAME->CRC boundary; run counter not reset between fields.
REQ-021 If the last CRC bit completes a run of 5, a stuff bit is sent before CRC_DEL.
REQ-022 FRAME sends 83 data bits, CRC 15 data bits, stuff bits excluded from both counts.
REQ-023 CRC_DEL, ACK_SLOT, ACK_DEL: one tick each, o_tx=1, no stuffing.
REQ-024 ACK_SLOT: i_rx sampled on the tick ending the slot; i_rx=1 latches ack error.
REQ-025 EOF: EOF_BITS ticks recessive; IFS: IFS_BITS ticks recessive; on the final IFS tick -> IDLE, o_busy=0, o_done=1 for one cycle, o_ack_err valid that cycle.
REQ-026 o_ack_err holds until next acceptance; cleared on acceptance.
REQ-027 Ticks absent: state, counters, o_tx hold indefinitely.

Reset
REQ-028 rst=1 asynchronously forces IDLE, o_tx=1, o_busy=0, o_done=0, o_ack_err=0, counters and shift registers 0.
REQ-029 rst mid-frame aborts immediately; no o_done; first i_start after rst release is accepted normally.

Structure
REQ-030 Shared CAN package holds: field widths (83, 15), state encoding, recessive/dominant constants, stuff limit 5.
REQ-031 One sub-module, can_bit_stuffer: run counter + last-bit register, asserts insert-stuff request; serializer FSM consumes it.
REQ-032 Tick-to-bit path registered; no combinational path from i_frame to o_tx.

Verification
REQ-033 i_frame=83'h0, i_crc=15'h0, tick every 4 clk -> 19 stuff bits (value 1) after every 5th zero, o_busy high for 130 ticks, then o_done.
REQ-034 i_frame alternating (bit82=0, bit0=0), i_crc=15'h5555 -> zero stuff bits, 98 data bits then 13 recessive, total 111 ticks.
REQ-035 Same i_frame, i_crc=15'h2A9F -> CRC bits 010101010011111, then stuff 0, then CRC_DEL 1; exactly one stuff bit.
REQ-036 i_rx=1 during ACK_SLOT -> o_ack_err=1 with o_done; i_rx=0 -> o_ack_err=0.
REQ-037 rst pulse at tick 40 of a frame -> o_tx=1 and o_busy=0 same cycle, no o_done; next i_start transmits full frame correctly.
REQ-038 i_start pulsed at ticks 10 and 60 of an active frame -> ignored; serial output identical to undisturbed run.
